fifo_flush_unpacker: RTL
========================

# fifo_flush_unpacker

Consumer-side block for the 32-bit flush word produced by the flush FIFO. Each flush word packs up to 8 nibbles, LSB nibble first, with unused upper slots padded with 4'hC. This block accepts one flush word at a time and strips the trailing padding. It replays the remaining nibbles one per beat on a valid/ready stream, marking the final nibble, and keeps word and empty-word counters for debug.

## Interface
Parameters:
- NIBBLES, 8, nibble slots per flush word; word width is 4*NIBBLES.
- PAD, 4'hC, padding nibble value.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_valid_i  input  1  flush word present on flush_data_i.
- flush_data_i  input  4*NIBBLES  packed word; slot k is bits [4k+3:4k]; slot 0 is the oldest nibble.
- flush_ready_o  output  1  block can accept a word this cycle.
- out_valid_o  output  1  nibble present on out_data_o.
- out_data_o  output  4  current nibble.
- out_last_o  output  1  current nibble is the final nibble of its word.
- out_ready_i  input  1  downstream accepts the nibble this cycle.
- busy_o  output  1  word is being unpacked (state UNPACK).
- word_cnt_o  output  CNT_W  non-empty words accepted; wraps modulo 2^CNT_W.
- empty_cnt_o  output  CNT_W  all-padding words accepted; wraps modulo 2^CNT_W.

## Operation
- Word length len = (highest slot index whose nibble != PAD) + 1. If every slot is PAD, len = 0. Range 0..NIBBLES. Width: $clog2(NIBBLES+1) bits.
- Only trailing PAD slots are padding. A PAD value below a non-PAD slot is data and is emitted. A genuine trailing 4'hC data nibble is indistinguishable from padding and is dropped; this is a documented limitation.
- States:
  - IDLE: flush_ready_o=1, out_valid_o=0.
    - Accept when flush_valid_i=1 (the accept condition is flush_valid_i=1 and flush_ready_o=1).
    - If len=0: empty_cnt_o+1 and stay in IDLE.
    - Otherwise: latch the word into a holding register, latch len, set idx=0, word_cnt_o+1, and go to UNPACK.
  - UNPACK: flush_ready_o=0, out_valid_o=1, out_data_o=hold[idx], out_last_o=(idx==len-1).
    - On out_ready_i=1 with out_last_o=0: idx+1.
    - On out_ready_i=1 with out_last_o=1: go to IDLE.
    - With out_ready_i=0: hold all outputs stable.
- out_data_o and out_last_o are 0 whenever out_valid_o=0.
- flush_valid_i while in UNPACK is ignored. The word is neither captured nor counted, and the upstream must hold it.
- An all-zero word with flush_valid_i=1 is a real word: len=8, eight 4'h0 nibbles.

## Timing
- Reset values: flush_ready_o=1, out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, word_cnt_o=0, empty_cnt_o=0, state IDLE, idx=0.
- Reset asserted mid-UNPACK: the next edge returns the block to IDLE and discards the held word. Counters clear. Reset has priority over every other event.
- Latency: word accepted at edge N, first nibble valid after edge N, i.e. in the cycle following acceptance.
- Throughput: with out_ready_i held at 1, a word of len L occupies L cycles in UNPACK plus 1 IDLE accept cycle, so back-to-back words take L+1 cycles each.
- Empty word: 1 cycle, no output beat, flush_ready_o stays 1.
- Counters update at the same edge as acceptance and are visible in the following cycle.
- Counter wrap: a counter at 2^CNT_W-1 returns to 0 on the next increment.

## Test plan
- Reset then word 32'hCCCC_C321 with out_ready_i=1 -> beats 1,2,3 on consecutive cycles; last=1 on 3; word_cnt_o=1; flush_ready_o returns to 1 the cycle after beat 3.
- Word 32'hCCCC_CCCC -> no out_valid_o; empty_cnt_o=1; flush_ready_o never drops.
- Word 32'hC5C7_C8C9 (interior PADs) -> beats 9,C,8,C,7,C,5 (len=7); last on 5.
- Word 32'h0000_0000 with out_ready_i toggling 1,0,1,0 -> eight 0 beats; data and last stable while stalled; last on the 8th.
- Second word presented while in UNPACK -> not accepted until IDLE, then accepted exactly once; word_cnt_o=2.
- Reset asserted on the 2nd beat of 32'hCCCC_4321 -> the next cycle is IDLE with out_valid_o=0 and counters 0. A subsequent word 32'hCCCC_CCC6 gives a single beat 6 with last=1.

Source files
------------

// File: rtl/fifo_flush_unpacker.sv
// fifo_flush_unpacker: accepts one packed flush word at a time, strips trailing
// padding nibbles and replays the remaining nibbles one per beat on a
// valid/ready stream, with debug counters for non-empty and all-padding words.
module fifo_flush_unpacker #(
  parameter int unsigned NIBBLES = 8,
  parameter logic [3:0]  PAD     = 4'hC,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_valid_i,
  input  logic [4*NIBBLES-1:0] flush_data_i,
  output logic                 flush_ready_o,
  output logic                 out_valid_o,
  output logic [3:0]           out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     word_cnt_o,
  output logic [CNT_W-1:0]     empty_cnt_o
);

  localparam int unsigned WORD_W = 4 * NIBBLES;
  localparam int unsigned LEN_W  = $clog2(NIBBLES + 1);
  localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    UNPACK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  hold_q, hold_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   empty_cnt_q, empty_cnt_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [3:0]         data_q, data_d;
  logic               last_q, last_d;
  logic [LEN_W-1:0]   len_c;

  // Length of the incoming word: one past the highest non-padding slot.
  always_comb begin
    len_c = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (flush_data_i[4*k +: 4] != PAD) begin
        len_c = LEN_W'(k + 1);
      end
    end
  end

  // Next-state logic plus next values of the registered stream outputs.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    len_d       = len_q;
    idx_d       = idx_q;
    word_cnt_d  = word_cnt_q;
    empty_cnt_d = empty_cnt_q;
    ready_d     = 1'b1;
    valid_d     = 1'b0;
    data_d      = 4'h0;
    last_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_valid_i) begin
          if (len_c == '0) begin
            empty_cnt_d = empty_cnt_q + CNT_W'(1);
          end else begin
            hold_d     = flush_data_i;
            len_d      = len_c;
            idx_d      = '0;
            word_cnt_d = word_cnt_q + CNT_W'(1);
            state_d    = UNPACK;
          end
        end
      end
      UNPACK: begin
        if (out_ready_i) begin
          if (last_q) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == UNPACK) begin
      ready_d = 1'b0;
      valid_d = 1'b1;
      data_d  = hold_d[{idx_d, 2'b00} +: 4];
      last_d  = ((LEN_W'(idx_d) + LEN_W'(1)) == len_d);
    end
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      word_cnt_q  <= '0;
      empty_cnt_q <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      data_q      <= 4'h0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      word_cnt_q  <= word_cnt_d;
      empty_cnt_q <= empty_cnt_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign flush_ready_o = ready_q;
  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_last_o    = last_q;
  assign busy_o        = valid_q;
  assign word_cnt_o    = word_cnt_q;
  assign empty_cnt_o   = empty_cnt_q;

endmodule
